// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;

    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic          ram_wren;
    logic [DW-1:0] ram_data_out;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rdata, a_rvalid,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid,
        output ram_address, ram_data_in, ram_wren,
        input  ram_data_out
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rdata, a_rvalid,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid,
        input  ram_address, ram_data_in, ram_wren,
        output ram_data_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (A = core, B = loader/DMA).
// Define DMEM_RR_EN for round-robin; default is A priority with a MAX_HOLD starvation guard.
module dmem_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    state_e        r_state;
    logic          r_rd_pend;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_a_rvalid;
    logic          w_b_rvalid;

`ifdef DMEM_RR_EN
    logic r_last_owner;  // 0: A, 1: B
`else
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);
    logic [HW-1:0] r_hold_cnt;
    logic          w_force_b;
`endif

    // Grants are held low throughout reset so the RAM is never written while it is asserted.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
`ifdef DMEM_RR_EN
        if (reset) begin
            if (bus.a_req && bus.b_req) begin
                w_gnt_a = r_last_owner;
                w_gnt_b = ~r_last_owner;
            end else begin
                w_gnt_a = bus.a_req;
                w_gnt_b = bus.b_req;
            end
        end
`else
        w_force_b = bus.a_req & bus.b_req & (r_hold_cnt == HoldMax);
        if (reset) begin
            w_gnt_a = bus.a_req & ~w_force_b;
            w_gnt_b = bus.b_req & (~bus.a_req | w_force_b);
        end
`endif
    end

    always_comb begin
        bus.ram_address = '0;
        bus.ram_data_in = '0;
        bus.ram_wren    = 1'b0;
        if (w_gnt_a) begin
            bus.ram_address = bus.a_addr;
            bus.ram_data_in = bus.a_wdata;
            bus.ram_wren    = bus.a_we;
        end else if (w_gnt_b) begin
            bus.ram_address = bus.b_addr;
            bus.ram_data_in = bus.b_wdata;
            bus.ram_wren    = bus.b_we;
        end
    end

    // Previous-cycle owner doubles as the read-return route.
    assign w_a_rvalid = r_rd_pend & (r_state == StOwnA);
    assign w_b_rvalid = r_rd_pend & (r_state == StOwnB);

    always_comb begin
        bus.a_gnt    = w_gnt_a;
        bus.b_gnt    = w_gnt_b;
        bus.a_rvalid = w_a_rvalid;
        bus.b_rvalid = w_b_rvalid;
        bus.a_rdata  = w_a_rvalid ? bus.ram_data_out : r_a_rdata;
        bus.b_rdata  = w_b_rvalid ? bus.ram_data_out : r_b_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_rd_pend <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
`ifdef DMEM_RR_EN
            r_last_owner <= 1'b0;
`else
            r_hold_cnt   <= '0;
`endif
        end else begin
            if (w_gnt_a) begin
                r_state <= StOwnA;
            end else if (w_gnt_b) begin
                r_state <= StOwnB;
            end else begin
                r_state <= StIdle;
            end
            r_rd_pend <= (w_gnt_a & ~bus.a_we) | (w_gnt_b & ~bus.b_we);
            if (w_a_rvalid) begin
                r_a_rdata <= bus.ram_data_out;
            end
            if (w_b_rvalid) begin
                r_b_rdata <= bus.ram_data_out;
            end
`ifdef DMEM_RR_EN
            if (w_gnt_a) begin
                r_last_owner <= 1'b0;
            end else if (w_gnt_b) begin
                r_last_owner <= 1'b1;
            end
`else
            if (w_gnt_b || !bus.b_req) begin
                r_hold_cnt <= '0;
            end else if (w_gnt_a && (r_hold_cnt != HoldMax)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a RAM stub and a transaction-level model.
// Honours DMEM_RR_EN the same way the design does.
module tb_dmem_arbiter;

    localparam int unsigned AW       = 10;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned DEPTH    = 1 << AW;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stub: synchronous read, write at the edge
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= ram_mem[bus.ram_address];
    end

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_a_rv, m_b_rv;
    logic [DW-1:0] m_a_rd, m_b_rd;
    int unsigned   m_streak;  // consecutive A wins while B waits
    int unsigned   m_last;    // 0: A last granted, 1: B

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a_rv   = 1'b0;
        m_b_rv   = 1'b0;
        m_a_rd   = '0;
        m_b_rd   = '0;
        m_streak = 0;
        m_last   = 0;
    endtask

    function automatic logic [1:0] model_grant(input logic ar, input logic br);
        logic ga, gb;
`ifdef DMEM_RR_EN
        if (ar && br) begin
            ga = (m_last == 1);
            gb = (m_last == 0);
        end else begin
            ga = ar;
            gb = br;
        end
`else
        gb = br && (!ar || m_streak >= MAX_HOLD);
        ga = ar && !gb;
`endif
        return {ga, gb};
    endfunction

    // Entered and left at posedge+1; drives one request cycle, checks at the falling edge.
    task automatic cycle(input logic ar, input logic aw, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic br, input logic bw,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         output logic [1:0] gnt_obs);
        logic [1:0]    g;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
        #4;
        g = model_grant(ar, br);
        exp_we   = g[1] ? aw : (g[0] ? bw : 1'b0);
        exp_addr = g[1] ? aa : (g[0] ? ba : '0);
        exp_data = g[1] ? ad : (g[0] ? bd : '0);
        gnt_obs  = {bus.a_gnt, bus.b_gnt};
        check_eq("a_gnt", 32'(bus.a_gnt), 32'(g[1]));
        check_eq("b_gnt", 32'(bus.b_gnt), 32'(g[0]));
        check_eq("ram_wren", 32'(bus.ram_wren), 32'(exp_we));
        check_eq("ram_address", 32'(bus.ram_address), 32'(exp_addr));
        check_eq("ram_data_in", bus.ram_data_in, exp_data);
        check_eq("a_rvalid", 32'(bus.a_rvalid), 32'(m_a_rv));
        check_eq("a_rdata", bus.a_rdata, m_a_rd);
        check_eq("b_rvalid", 32'(bus.b_rvalid), 32'(m_b_rv));
        check_eq("b_rdata", bus.b_rdata, m_b_rd);
        m_a_rv = g[1] && !aw;
        m_b_rv = g[0] && !bw;
        if (m_a_rv) m_a_rd = m_mem[aa];
        if (m_b_rv) m_b_rd = m_mem[ba];
        if (g[1] && aw) m_mem[aa] = ad;
        if (g[0] && bw) m_mem[ba] = bd;
        if (g[0] || !br) m_streak = 0;
        else if (g[1] && m_streak < MAX_HOLD) m_streak++;
        if (g[1]) m_last = 0;
        else if (g[0]) m_last = 1;
        @(posedge clk);
        #1;
    endtask

    // Starts an A read (plus a B write when both_req), then asserts reset before the edge.
    task automatic pulse_reset(input logic both_req);
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 10'd7; bus.a_wdata = '0;
        bus.b_req = both_req; bus.b_we = 1'b1; bus.b_addr = 10'd8; bus.b_wdata = 32'hA5A5A5A5;
        #2;
        if (!both_req) check_eq("pre_rst_a_gnt", 32'(bus.a_gnt), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
        check_eq("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
        check_eq("rst_wren", 32'(bus.ram_wren), 32'd0);
        check_eq("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_eq("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check_eq("rst_a_rdata", bus.a_rdata, 32'd0);
        check_eq("rst_b_rdata", bus.b_rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_hold_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        reset = 1'b1;
    endtask

    logic [1:0] gnt;
    logic [1:0] pat [10];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram_mem[i] <= 32'(i) * 32'h9E3779B1;
            m_mem[i]    = 32'(i) * 32'h9E3779B1;
        end
        ram_mem[5] <= 32'hDEADBEEF;
        m_mem[5]    = 32'hDEADBEEF;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("init_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_eq("init_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check_eq("init_wren", 32'(bus.ram_wren), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // A read alone from address 5
        cycle(1, 0, 10'd5, '0, 0, 0, '0, '0, gnt);
        check_eq("t2_a_rvalid", 32'(bus.a_rvalid), 32'd1);
        check_eq("t2_a_rdata", bus.a_rdata, 32'hDEADBEEF);
        check_eq("t2_b_rvalid", 32'(bus.b_rvalid), 32'd0);

        // B write then A read of the same word
        cycle(0, 0, '0, '0, 1, 1, 10'd10, 32'h12345678, gnt);
        cycle(1, 0, 10'd10, '0, 0, 0, '0, '0, gnt);
        check_eq("t3_a_rdata", bus.a_rdata, 32'h12345678);
        cycle(0, 0, '0, '0, 0, 0, '0, '0, gnt);

        // Contention with both requests held
        cycle(1, 0, 10'd1, '0, 0, 0, '0, '0, gnt);
`ifdef DMEM_RR_EN
        for (int i = 0; i < 10; i++) pat[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
        for (int i = 0; i < 10; i++) pat[i] = (i % 5 == 4) ? 2'b01 : 2'b10;
`endif
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 10'd2, '0, 1, 0, 10'd3, '0, gnt);
            check_eq($sformatf("pattern[%0d]", i), 32'(gnt), 32'(pat[i]));
        end

        // Reset mid-activity, then reset right after an A read grant
        pulse_reset(1'b1);
        cycle(0, 0, '0, '0, 0, 0, '0, '0, gnt);
        pulse_reset(1'b0);
        cycle(0, 0, '0, '0, 0, 0, '0, '0, gnt);
        check_eq("t6_no_rvalid", 32'(bus.a_rvalid), 32'd0);
        cycle(0, 0, '0, '0, 0, 0, '0, '0, gnt);

        // Randomized traffic over a small address window to exercise read-after-write
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                pulse_reset(1'($urandom_range(0, 1)));
            end
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), $urandom, gnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
